// File: rtl/seg7_scan_n.sv
// Multiplexed seven-segment driver: periodic sample, shift-and-add-3 BCD conversion
// (or hex pass-through), leading-zero blanking, overflow dashes and per-digit decimal points.
//   state  | meaning
//   IDLE   | waiting for the sample tick
//   CONV   | one double-dabble shift per cycle, IN_W cycles
//   COMMIT | load display register and overflow, one cycle
module seg7_scan_n #(
  parameter int DIGITS       = 4,
  parameter int IN_W         = 16,
  parameter int SAMPLE_TICKS = 100000000,
  parameter int SCAN_TICKS   = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   sw,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_in,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        ledSEG,
  output logic              dp,
  output logic              overflow,
  output logic              conv_busy
);

  localparam int BW    = 4 * DIGITS;
  localparam int SMP_W = $clog2(SAMPLE_TICKS);
  localparam int SCN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int POS_W = $clog2(DIGITS);
  localparam int BIT_W = $clog2(IN_W);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_TICKS - 1);
  localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_TICKS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            state, state_nx;
  logic [SMP_W-1:0]  smp_cnt;
  logic              tick;
  logic [IN_W-1:0]   shreg;
  logic              hex_lat;
  logic [BW-1:0]     bcd, bcd_adj, hex_val, disp;
  logic              ovf_sticky;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SCN_W-1:0]  scn_cnt;
  logic [POS_W-1:0]  pos, dig;
  logic [3:0]        nib;
  logic [DIGITS-1:0] lz, an_nx;
  logic [6:0]        seg_nx;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign tick      = (smp_cnt == SMP_LAST);
  assign conv_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       smp_cnt <= '0;
    else if (tick) smp_cnt <= '0;
    else           smp_cnt <= smp_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = hex_mode ? COMMIT : CONV;
      CONV:    if (bit_cnt == BIT_LAST) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  generate
    if (IN_W >= BW) begin : g_hex_trunc
      assign hex_val = shreg[BW-1:0];
    end else begin : g_hex_ext
      assign hex_val = {{(BW-IN_W){1'b0}}, shreg};
    end
  endgenerate

  // The shift register doubles as the latched sample, so hex commits read it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      hex_lat    <= 1'b0;
      bcd        <= '0;
      ovf_sticky <= 1'b0;
      bit_cnt    <= '0;
      disp       <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          shreg   <= sw;
          hex_lat <= hex_mode;
          bit_cnt <= '0;
          if (!hex_mode) begin
            bcd        <= '0;
            ovf_sticky <= 1'b0;
          end
        end
        CONV: begin
          {bcd, shreg} <= {bcd_adj[BW-2:0], shreg, 1'b0};
          if (bcd_adj[BW-1]) ovf_sticky <= 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        COMMIT: begin
          if (hex_lat) begin
            disp     <= hex_val;
            overflow <= 1'b0;
          end else begin
            disp     <= bcd;
            overflow <= ovf_sticky;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scn_cnt <= '0;
      pos     <= '0;
    end else if (scn_cnt == SCN_LAST) begin
      scn_cnt <= '0;
      pos     <= (pos == POS_LAST) ? '0 : pos + 1'b1;
    end else begin
      scn_cnt <= scn_cnt + 1'b1;
    end
  end

  assign dig = POS_LAST - pos;

  // lz[d] is set when digit d and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp[BW-1 -: 4] == 4'd0);
    for (int d = DIGITS - 2; d >= 0; d--)
      lz[d] = lz[d+1] && (disp[4*d +: 4] == 4'd0);
    nib   = disp[{dig, 2'b00} +: 4];
    an_nx = ~(DIGITS'(1) << dig);
    if (overflow)                              seg_nx = 7'b1111110;
    else if (blank_lz && dig != '0 && lz[dig]) seg_nx = 7'b1111111;
    else                                       seg_nx = glyph(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN     <= '1;
      ledSEG <= 7'b1111111;
      dp     <= 1'b1;
    end else begin
      AN     <= an_nx;
      ledSEG <= seg_nx;
      dp     <= ~dp_in[dig];
    end
  end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n: stimulus pushes arithmetic-model expectations,
// a monitor pops one on every conversion commit and checks a full display frame.
module tb_seg7_scan_n;
  localparam int DIGITS = 4, IN_W = 16, SAMPLE_TICKS = 40, SCAN_TICKS = 2;
  localparam int FRAME = DIGITS * SCAN_TICKS;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] sw = '0;
  logic        hex_mode = 1'b0, blank_lz = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  AN;
  logic [6:0]  ledSEG;
  logic        dp, overflow, conv_busy;

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [27:0] segs;
    logic [3:0]  dpn;
    logic        ovf;
    logic [7:0]  busy;
  } exp_t;
  exp_t q[$];

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg7_scan_n #(.DIGITS(DIGITS), .IN_W(IN_W), .SAMPLE_TICKS(SAMPLE_TICKS),
                .SCAN_TICKS(SCAN_TICKS)) dut (
    .clk(clk), .rst(rst), .sw(sw), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .dp_in(dp_in), .AN(AN), .ledSEG(ledSEG), .dp(dp), .overflow(overflow),
    .conv_busy(conv_busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame from plain arithmetic: digit d = (v / base^d) % base.
  function automatic exp_t model(input logic [15:0] v, input logic hx, input logic bl,
                                 input logic [3:0] dpi);
    exp_t e;
    int   val, base, pw, dv;
    val    = int'(v);
    base   = hx ? 16 : 10;
    e.ovf  = !hx && (val >= 10000);
    e.busy = hx ? 8'd1 : 8'(IN_W + 1);
    e.dpn  = ~dpi;
    e.segs = '0;
    for (int d = 0; d < DIGITS; d++) begin
      pw = base ** d;
      dv = (val / pw) % base;
      if (e.ovf)                      e.segs[7*d +: 7] = 7'b1111110;
      else if (bl && d > 0 && val < pw) e.segs[7*d +: 7] = 7'b1111111;
      else                            e.segs[7*d +: 7] = GLYPH[dv];
    end
    return e;
  endfunction

  // One settle cycle for the output register, then one full frame of samples.
  task automatic capture(output logic [27:0] segs, output logic [3:0] dpn, output int bad);
    int seen [DIGITS];
    int last, d;
    bad = 0; segs = '0; dpn = '1; last = -1;
    foreach (seen[i]) seen[i] = 0;
    @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      d = -1;
      for (int i = 0; i < DIGITS; i++) if (AN == ~(4'(1) << i)) d = i;
      if (d < 0) bad++;
      else begin
        seen[d]++;
        segs[7*d +: 7] = ledSEG;
        dpn[d] = dp;
        if (last >= 0 && d != last && d != (last + DIGITS - 1) % DIGITS) bad++;
        last = d;
      end
    end
    foreach (seen[i]) if (seen[i] != SCAN_TICKS) bad++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_AN"}, AN, 4'hF);
    chk({tag, "_ledSEG"}, ledSEG, 7'h7F);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_conv_busy"}, conv_busy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    exp_t e;
    logic [27:0] s;
    logic [3:0]  dn;
    int bad;
    blank_lz = 1'b0;
    dp_in    = '0;
    e = model(16'd0, 1'b0, 1'b0, 4'd0);
    capture(s, dn, bad);
    chk({tag, "_segs"}, s, e.segs);
    chk({tag, "_dp"}, dn, e.dpn);
    chk({tag, "_scan"}, bad, 0);
    chk({tag, "_overflow"}, overflow, 1'b0);
  endtask

  // Inputs held across the tick; sw/hex_mode scrambled right after it.
  task automatic run_sample(input int pre, input logic [15:0] v, input logic hx,
                            input logic bl, input logic [3:0] dpi);
    sw = v; hex_mode = hx; blank_lz = bl; dp_in = dpi;
    q.push_back(model(v, hx, bl, dpi));
    repeat (pre) @(posedge clk);
    #1;
    sw = 16'($urandom);
    hex_mode = 1'($urandom);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int pre);
    logic [15:0] v;
    int m;
    m = $urandom_range(0, 3);
    case (m)
      0: v = 16'($urandom);
      1: v = 16'($urandom_range(0, 9999));
      2: v = 16'($urandom_range(0, 99));
      default: v = 16'($urandom_range(0, 9));
    endcase
    run_sample(pre, v, $urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom));
  endtask

  initial begin : monitor
    logic prev;
    int blen, bad;
    exp_t e;
    logic [27:0] s;
    logic [3:0] dn;
    prev = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        blen = 0;
      end else begin
        if (conv_busy) blen++;
        if (prev && !conv_busy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got a commit with no sample outstanding");
          end else begin
            e = q.pop_front();
            chk("busy_len", blen, e.busy);
            chk("overflow", overflow, e.ovf);
            capture(s, dn, bad);
            chk("segments", s, e.segs);
            chk("dp", dn, e.dpn);
            chk("scan_order", bad, 0);
          end
          blen = 0;
        end
        prev = conv_busy;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    check_zero("after_por");

    run_sample(31, 16'd1234,  1'b0, 1'b0, 4'b0000);
    run_sample(10, 16'hBEEF,  1'b1, 1'b0, 4'b0000);
    run_sample(10, 16'd12345, 1'b0, 1'b0, 4'b0000);
    run_sample(10, 16'd9999,  1'b0, 1'b0, 4'b0000);
    run_sample(10, 16'd7,     1'b0, 1'b1, 4'b0000);
    run_sample(10, 16'd0,     1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 16; i++) run_random(10);

    sw = 16'd4321; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = '0;
    repeat (10) @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_mid_conv", conv_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("mid_conv");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero("after_mid_rst");

    run_random(31);
    for (int i = 0; i < 3; i++) run_random(10);

    chk("pending_commits", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
